// File: rtl/hififo_pkg.sv
// Shared definitions for the hififo read-request path: arbiter FSM states and
// default tag/outstanding sizing.
package hififo_pkg;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StHalt
  } hififo_state_e;

  localparam int unsigned TbitsDefault  = 5;
  localparam int unsigned MaxoutDefault = 8;

endpackage

// File: rtl/hififo_rr_priority_pick.sv
// Rotating priority encoder: returns the first set request at or after start_i,
// wrapping around.
module hififo_rr_priority_pick #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] cand;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'((32'(start_i) + k) % N);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/hififo_rr_arbiter.sv
// Round-robin read-request arbiter with tag allocation, per-source outstanding
// limits, completion tracking and an abort/drain/halt sequence.
module hififo_rr_arbiter
  import hififo_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned AMSB   = 63,
  parameter int unsigned TBITS  = TbitsDefault,
  parameter int unsigned MAXOUT = MaxoutDefault
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*(AMSB+1)-1:0]   req_addr,
  output logic [NREQ-1:0]            req_ready,
  output logic                       out_valid,
  output logic [AMSB:0]              out_addr,
  output logic [TBITS-1:0]           out_tag,
  input  logic                       out_ready,
  input  logic                       rc_valid,
  input  logic [TBITS-1:0]           rc_tag,
  input  logic                       rc_last,
  output logic [NREQ-1:0]            rc_done,
  input  logic                       abort,
  output logic                       halted,
  output logic                       err_tag
);

  localparam int unsigned NTAGS = 2 ** TBITS;
  localparam int unsigned SW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW    = $clog2(MAXOUT + 1);
  localparam int unsigned AW    = AMSB + 1;

  hififo_state_e    state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [AMSB:0]    out_addr_q, out_addr_d;
  logic [TBITS-1:0] out_tag_q, out_tag_d;
  logic [NTAGS-1:0] busy_q, busy_d;
  logic [SW-1:0]    owner_q [NTAGS];
  logic [CW-1:0]    cnt_q [NREQ];
  logic [CW-1:0]    cnt_d [NREQ];
  logic [SW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]  rc_done_q, rc_done_d;
  logic             err_q, err_d;

  logic [NREQ-1:0]  eligible;
  logic             src_found, tag_found, load_ok, grant;
  logic [SW-1:0]    src_idx;
  logic [TBITS-1:0] tag_idx;
  logic             release_tag;
  logic [SW-1:0]    rel_owner;

  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      eligible[i] = req_valid[i] && (cnt_q[i] < CW'(MAXOUT));
    end
  end

  hififo_rr_priority_pick #(
    .N (NREQ)
  ) u_src_pick (
    .req_i   (eligible),
    .start_i (rr_ptr_q),
    .valid_o (src_found),
    .idx_o   (src_idx)
  );

  // Same encoder with a fixed start of 0 yields the lowest free tag.
  hififo_rr_priority_pick #(
    .N (NTAGS)
  ) u_tag_pick (
    .req_i   (~busy_q),
    .start_i ('0),
    .valid_o (tag_found),
    .idx_o   (tag_idx)
  );

  assign load_ok     = (state_q == StRun) && (!out_valid_q || out_ready);
  assign grant       = load_ok && src_found && tag_found;
  assign release_tag = rc_valid && rc_last && busy_q[rc_tag];
  assign rel_owner   = owner_q[rc_tag];

  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = grant && (src_idx == SW'(i));
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (release_tag) busy_d[rc_tag] = 1'b0;
    if (grant)       busy_d[tag_idx] = 1'b1;

    out_valid_d = out_valid_q && !out_ready;
    out_addr_d  = out_addr_q;
    out_tag_d   = out_tag_q;
    rr_ptr_d    = rr_ptr_q;
    if (grant) begin
      out_valid_d = 1'b1;
      out_addr_d  = req_addr[32'(src_idx) * AW +: AW];
      out_tag_d   = tag_idx;
      rr_ptr_d    = (32'(src_idx) == NREQ - 1) ? '0 : src_idx + SW'(1);
    end

    // Increment and decrement may hit the same source in one cycle.
    for (int unsigned i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i] + CW'(grant && (src_idx == SW'(i)))
                          - CW'(release_tag && (rel_owner == SW'(i)));
    end

    rc_done_d = '0;
    if (release_tag) rc_done_d[rel_owner] = 1'b1;
    err_d = err_q | (rc_valid && rc_last && !busy_q[rc_tag]);

    state_d = state_q;
    case (state_q)
      StRun:   if (abort) state_d = StDrain;
      StDrain: if (!out_valid_d && (busy_d == '0)) state_d = StHalt;
      StHalt:  if (!abort) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StRun;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_tag_q   <= '0;
      busy_q      <= '0;
      rr_ptr_q    <= '0;
      rc_done_q   <= '0;
      err_q       <= 1'b0;
      for (int unsigned t = 0; t < NTAGS; t++) owner_q[t] <= '0;
      for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_tag_q   <= out_tag_d;
      busy_q      <= busy_d;
      rr_ptr_q    <= rr_ptr_d;
      rc_done_q   <= rc_done_d;
      err_q       <= err_d;
      if (grant) owner_q[tag_idx] <= src_idx;
      for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_tag   = out_tag_q;
  assign rc_done   = rc_done_q;
  assign halted    = (state_q == StHalt);
  assign err_tag   = err_q;

endmodule

// File: tb/tb_hififo_rr_arbiter.sv
// Directed bench for hififo_rr_arbiter; granted requests are queued as expected
// out_* entries and compared when the output handshake happens.
module tb_hififo_rr_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned TBITS = 5;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*64-1:0] req_addr;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic [63:0]       out_addr;
  logic [TBITS-1:0]  out_tag;
  logic              out_ready;
  logic              rc_valid;
  logic [TBITS-1:0]  rc_tag;
  logic              rc_last;
  logic [NREQ-1:0]   rc_done;
  logic              abort;
  logic              halted;
  logic              err_tag;

  typedef struct {
    logic [63:0]      addr;
    logic [TBITS-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   seq[3] = '{3, 0, 1};

  always #5 clock = ~clock;

  hififo_rr_arbiter u_dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_addr  (out_addr),
    .out_tag   (out_tag),
    .out_ready (out_ready),
    .rc_valid  (rc_valid),
    .rc_tag    (rc_tag),
    .rc_last   (rc_last),
    .rc_done   (rc_done),
    .abort     (abort),
    .halted    (halted),
    .err_tag   (err_tag)
  );

  function automatic logic [63:0] src_addr(input int s);
    return 64'(s + 1) << 12;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Sample at the falling edge; retire one scoreboard entry per output handshake.
  task automatic look();
    exp_t e;
    @(negedge clock);
    if (out_valid && out_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected observed tag=%0h expected no output", out_tag);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_addr", out_addr, e.addr);
        chk("out_tag", 64'(out_tag), 64'(e.tag));
      end
    end
  endtask

  task automatic grant(input int src, input int tag);
    exp_t e;
    chk("grant", 64'(req_ready), 64'(1) << src);
    e.addr = src_addr(src);
    e.tag  = TBITS'(tag);
    sb.push_back(e);
  endtask

  task automatic drive_rc(input logic v, input logic l, input int tag);
    rc_valid = v;
    rc_last  = l;
    rc_tag   = TBITS'(tag);
  endtask

  task automatic complete(input int tag, input int owner);
    drive_rc(1'b1, 1'b1, tag);
    look();
    tick();
    drive_rc(1'b0, 1'b0, 0);
    look();
    chk("rc_done", 64'(rc_done), 64'(1) << owner);
    tick();
  endtask

  initial begin
    for (int s = 0; s < int'(NREQ); s++) req_addr[s*64 +: 64] = src_addr(s);
    reset_n = 1'b0; req_valid = '0; out_ready = 1'b0; abort = 1'b0;
    drive_rc(1'b0, 1'b0, 0);

    // Reset state
    look();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_addr", out_addr, 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rc_done", 64'(rc_done), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_err_tag", 64'(err_tag), 64'd0);
    tick();
    reset_n = 1'b1;

    // All sources valid: grants 0,1,2,3,0 with tags 0..4
    req_valid = '1; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin look(); grant(k % 4, k); tick(); end
    req_valid = '0;
    look(); chk("a_idle", 64'(req_ready), 64'd0); tick();
    for (int t = 0; t < 5; t++) complete(t, t % 4);

    // Source 2 alone: blocked after 8 outstanding, one completion reopens it
    req_valid = 4'b0100;
    for (int k = 0; k < 8; k++) begin look(); grant(2, k); tick(); end
    for (int k = 0; k < 2; k++) begin
      look(); chk("b_limit", 64'(req_ready), 64'd0); tick();
    end
    drive_rc(1'b1, 1'b1, 3);
    look(); chk("b_limit_rc", 64'(req_ready), 64'd0); tick();
    drive_rc(1'b0, 1'b0, 0);
    look(); chk("b_rc_done", 64'(rc_done), 64'd4); grant(2, 3); tick();
    req_valid = '0;
    look(); tick();

    // Fill all 32 tags, then free tag 7 with requests pending
    req_valid = 4'b1011;
    for (int k = 0; k < 24; k++) begin look(); grant(seq[k % 3], 8 + k); tick(); end
    req_valid = '1;
    look(); chk("c_full", 64'(req_ready), 64'd0); tick();
    drive_rc(1'b1, 1'b1, 7);
    look(); chk("c_full_rc", 64'(req_ready), 64'd0); tick();
    drive_rc(1'b0, 1'b0, 0);
    look(); chk("c_rc_done", 64'(rc_done), 64'd4); grant(2, 7); tick();

    // Output stall for 5 cycles while a tag frees up
    out_ready = 1'b0;
    drive_rc(1'b1, 1'b1, 8);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) drive_rc(1'b0, 1'b0, 0);
      look();
      chk("d_valid", 64'(out_valid), 64'd1);
      chk("d_tag", 64'(out_tag), 64'd7);
      chk("d_addr", out_addr, src_addr(2));
      chk("d_no_grant", 64'(req_ready), 64'd0);
      if (k == 1) chk("d_rc_done", 64'(rc_done), 64'd8);
      tick();
    end
    out_ready = 1'b1;
    look(); grant(3, 8); tick();
    req_valid = '0;
    look(); tick();

    // Non-final beat, real completion, then completion on the freed tag
    drive_rc(1'b1, 1'b0, 9);
    look(); tick();
    drive_rc(1'b0, 1'b0, 0);
    look();
    chk("e_nonlast_done", 64'(rc_done), 64'd0);
    chk("e_nonlast_err", 64'(err_tag), 64'd0);
    tick();
    complete(9, 0);
    drive_rc(1'b1, 1'b1, 9);
    look(); tick();
    drive_rc(1'b0, 1'b0, 0);
    look();
    chk("e_err_tag", 64'(err_tag), 64'd1);
    chk("e_no_done", 64'(rc_done), 64'd0);
    tick();
    req_valid = 4'b0001;
    look(); grant(0, 9); tick();
    req_valid = '0;
    look(); chk("e_idle", 64'(req_ready), 64'd0); tick();

    // Reset mid-transfer drops ownership; later completion is an error
    reset_n = 1'b0;
    look();
    chk("r_out_valid", 64'(out_valid), 64'd0);
    chk("r_err_clear", 64'(err_tag), 64'd0);
    chk("r_rc_done", 64'(rc_done), 64'd0);
    tick();
    sb.delete();
    reset_n = 1'b1;
    drive_rc(1'b1, 1'b1, 5);
    look(); tick();
    drive_rc(1'b0, 1'b0, 0);
    look();
    chk("r_err_tag", 64'(err_tag), 64'd1);
    chk("r_no_done", 64'(rc_done), 64'd0);
    tick();

    // Abort with 3 tags busy, abort released mid-drain
    req_valid = 4'b0111;
    for (int k = 0; k < 3; k++) begin look(); grant(k, k); tick(); end
    req_valid = '0; abort = 1'b1;
    look(); chk("f_abort_idle", 64'(req_ready), 64'd0); tick();
    req_valid = '1;
    look();
    chk("f_drain_nogrant", 64'(req_ready), 64'd0);
    chk("f_drain_halted", 64'(halted), 64'd0);
    tick();
    drive_rc(1'b1, 1'b1, 0);
    look(); chk("f_drain_nogrant2", 64'(req_ready), 64'd0); tick();
    drive_rc(1'b0, 1'b0, 0); abort = 1'b0;
    look();
    chk("f_done0", 64'(rc_done), 64'd1);
    chk("f_stay_drain", 64'(req_ready), 64'd0);
    chk("f_halted0", 64'(halted), 64'd0);
    tick();
    drive_rc(1'b1, 1'b1, 1);
    look(); tick();
    drive_rc(1'b0, 1'b0, 0);
    look();
    chk("f_done1", 64'(rc_done), 64'd2);
    chk("f_stay_drain2", 64'(req_ready), 64'd0);
    chk("f_halted1", 64'(halted), 64'd0);
    tick();
    drive_rc(1'b1, 1'b1, 2);
    look();
    chk("f_halted_pre", 64'(halted), 64'd0);
    chk("f_nogrant_pre", 64'(req_ready), 64'd0);
    tick();
    drive_rc(1'b0, 1'b0, 0);
    look();
    chk("f_halted", 64'(halted), 64'd1);
    chk("f_done2", 64'(rc_done), 64'd4);
    chk("f_halt_nogrant", 64'(req_ready), 64'd0);
    tick();
    look();
    chk("f_resume_halted", 64'(halted), 64'd0);
    grant(3, 0);
    tick();
    req_valid = '0;
    look(); tick();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
